// File: rtl/cache_sim_pkg.sv
// Shared constants and types for the sectored cache simulator.
// Line geometry is common to the cache model and the refill responder.
package cache_sim_pkg;

  localparam int unsigned ADDR_W      = 31;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned LINE_BYTES  = 32;
  localparam int unsigned BEATS       = LINE_BYTES / 4;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned BEAT_W      = OFFSET_BITS - 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  // One response beat as presented on the refill bus.
  typedef struct packed {
    logic                 valid;
    logic                 last;
    addr_t                addr;
    logic [WORD_BITS-1:0] data;
  } rsp_beat_t;

  function automatic addr_t line_base(addr_t a);
    return a & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

  function automatic beat_t word_index(addr_t a);
    return a[OFFSET_BITS-1:2];
  endfunction

  function automatic addr_t beat_addr(addr_t base, beat_t sel);
    return base | (ADDR_W'(sel) << 2);
  endfunction

endpackage

// File: rtl/sector_refill_responder_if.sv
// Request/response bus between the cache model (master) and the refill responder (slave).
interface sector_refill_responder_if;
  import cache_sim_pkg::*;

  logic                 req_valid_41;
  logic                 req_ready_41;
  addr_t                req_addr_41;
  logic                 rsp_valid_41;
  logic                 rsp_ready_41;
  addr_t                rsp_addr_41;
  logic [WORD_BITS-1:0] rsp_data_41;
  logic                 rsp_last_41;

  modport master (
    output req_valid_41, req_addr_41, rsp_ready_41,
    input  req_ready_41, rsp_valid_41, rsp_addr_41, rsp_data_41, rsp_last_41
  );

  modport slave (
    input  req_valid_41, req_addr_41, rsp_ready_41,
    output req_ready_41, rsp_valid_41, rsp_addr_41, rsp_data_41, rsp_last_41
  );

endinterface

// File: rtl/refill_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through head and async active-high reset.
// Pushes while full and pops while empty are ignored.
module refill_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 31
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_c_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push  = push_i & ~full_q;
  assign do_pop   = pop_i & ~empty_q;
  assign count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  assign dout_c_o = mem_q[rd_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers and flags; flags are registered from the next count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/sector_refill_responder.sv
// Memory-side refill responder: queues line misses and returns each line as a burst of
// pattern-generated words. CRITICAL_WORD_FIRST_EN starts each burst at the requested word.
module sector_refill_responder
  import cache_sim_pkg::*;
#(
  parameter int unsigned          LATENCY    = 4,
  parameter logic [WORD_BITS-1:0] SEED       = 32'hC0DE_0000,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                      clk_41,
  input  logic                      rst_41,
  sector_refill_responder_if.slave  bus,
  output logic                      busy_41,
  output logic [ADDR_W-1:0]         refills_41
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  beat_t            idx_q, idx_d;
  addr_t            base_q, base_d;
  rsp_beat_t        rsp_q, rsp_d;
  addr_t            refills_q, refills_d;
  logic             busy_q, busy_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  addr_t            fifo_dout;
  logic [CNT_W-1:0] fifo_count, fifo_count_d;
  beat_t            sel_idle, sel_wait, sel_next;

  assign fifo_push = bus.req_valid_41 & ~fifo_full;

  refill_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .clk_i    (clk_41),
    .rst_i    (rst_41),
    .push_i   (fifo_push),
    .din_i    (bus.req_addr_41),
    .pop_i    (fifo_pop),
    .dout_c_o (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

`ifdef CRITICAL_WORD_FIRST_EN
  beat_t widx_q, widx_d;
  assign sel_idle = word_index(fifo_dout);
  assign sel_wait = widx_q;
  assign sel_next = widx_q + idx_q + beat_t'(1);

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) widx_q <= '0;
    else        widx_q <= widx_d;
  end
`else
  assign sel_idle = '0;
  assign sel_wait = '0;
  assign sel_next = idx_q + beat_t'(1);
`endif

  function automatic rsp_beat_t make_beat(addr_t base, beat_t sel, logic last);
    rsp_beat_t b;
    b.valid = 1'b1;
    b.last  = last;
    b.addr  = beat_addr(base, sel);
    b.data  = {1'b0, b.addr} ^ SEED;
    return b;
  endfunction

  // Next-state, beat sequencing and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    base_d    = base_q;
    rsp_d     = rsp_q;
    refills_d = refills_q;
    fifo_pop  = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
    widx_d    = widx_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          base_d   = line_base(fifo_dout);
          idx_d    = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          widx_d   = sel_idle;
`endif
          if (LATENCY == 0) begin
            state_d = BURST;
            rsp_d   = make_beat(base_d, sel_idle, 1'b0);
          end else begin
            state_d = WAIT;
            cnt_d   = 8'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = BURST;
          rsp_d   = make_beat(base_q, sel_wait, 1'b0);
        end
      end
      BURST: begin
        if (rsp_q.valid && bus.rsp_ready_41) begin
          if (rsp_q.last) begin
            rsp_d.valid = 1'b0;
            rsp_d.last  = 1'b0;
            refills_d   = refills_q + ADDR_W'(1);
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + beat_t'(1);
            rsp_d = make_beat(base_q, sel_next, idx_q == beat_t'(BEATS - 2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
    fifo_count_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop & ~fifo_empty);
    busy_d       = (state_d != IDLE) || (fifo_count_d != '0);
  end

  always_ff @(posedge clk_41 or posedge rst_41) begin
    if (rst_41) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      rsp_q     <= '0;
      refills_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      rsp_q     <= rsp_d;
      refills_q <= refills_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_ready_41 = ~fifo_full;
  assign bus.rsp_valid_41 = rsp_q.valid;
  assign bus.rsp_last_41  = rsp_q.last;
  assign bus.rsp_addr_41  = rsp_q.addr;
  assign bus.rsp_data_41  = rsp_q.data;
  assign busy_41          = busy_q;
  assign refills_41       = refills_q;

endmodule

// File: tb/tb_sector_refill_responder.sv
// Directed self-checking bench for sector_refill_responder (LATENCY=4 and LATENCY=0 instances).
// Honours CRITICAL_WORD_FIRST_EN when choosing the expected beat order.
module tb_sector_refill_responder;
  import cache_sim_pkg::*;

  localparam logic [31:0] SEED = 32'hC0DE_0000;

  logic clk_41 = 1'b0;
  logic rst_41 = 1'b1;
  always #5 clk_41 = ~clk_41;

  sector_refill_responder_if if4 ();
  sector_refill_responder_if if0 ();

  logic        busy4, busy0;
  logic [30:0] ref4, ref0;

  sector_refill_responder #(.LATENCY(4)) u_dut4 (
    .clk_41(clk_41), .rst_41(rst_41), .bus(if4), .busy_41(busy4), .refills_41(ref4)
  );
  sector_refill_responder #(.LATENCY(0)) u_dut0 (
    .clk_41(clk_41), .rst_41(rst_41), .bus(if0), .busy_41(busy0), .refills_41(ref0)
  );

  int   checks = 0;
  int   failures = 0;
  logic push_pending = 1'b0;

  function automatic logic [30:0] exp_addr(logic [30:0] req, int i);
    logic [30:0] base;
    int w;
    base = req & ~31'h1F;
`ifdef CRITICAL_WORD_FIRST_EN
    w = (int'(req[4:2]) + i) % 8;
`else
    w = i;
`endif
    return base + 31'(4 * w);
  endfunction

  function automatic logic [31:0] exp_data(logic [30:0] a);
    return {1'b0, a} ^ SEED;
  endfunction

  task automatic send_req4(input logic [30:0] a);
    @(negedge clk_41);
    if4.req_valid_41 = 1'b1;
    if4.req_addr_41  = a;
    checks++;
    if (if4.req_ready_41 !== 1'b1) begin
      failures++;
      $display("FAIL send_ready addr=%h: got %b expected 1", a, if4.req_ready_41);
    end
    @(posedge clk_41);
    #2 if4.req_valid_41 = 1'b0;
  endtask

  // Accept beats of one line on if4 until stop_at beats are taken; optional stall.
  task automatic collect4(input logic [30:0] req, input int stop_at,
                          input int stall_beat, input int stall_cycles);
    int i = 0;
    int stall_left = stall_cycles;
    int guard = 0;
    while (i < stop_at && guard < 200) begin
      @(negedge clk_41);
      guard++;
      if (push_pending) begin
        if4.req_valid_41 = 1'b0;
        push_pending = 1'b0;
      end else if (if4.req_valid_41 && if4.req_ready_41) begin
        push_pending = 1'b1;
      end
      if (i == stall_beat && stall_left > 0 && if4.rsp_valid_41) begin
        if4.rsp_ready_41 = 1'b0;
        stall_left--;
        checks++;
        if (if4.rsp_addr_41 !== exp_addr(req, i) || if4.rsp_data_41 !== exp_data(exp_addr(req, i))) begin
          failures++;
          $display("FAIL stall_hold beat%0d: addr=%h data=%h expected addr=%h data=%h",
                   i, if4.rsp_addr_41, if4.rsp_data_41, exp_addr(req, i), exp_data(exp_addr(req, i)));
        end
      end else begin
        if4.rsp_ready_41 = 1'b1;
        if (if4.rsp_valid_41) begin
          checks++;
          if (if4.rsp_addr_41 !== exp_addr(req, i) || if4.rsp_data_41 !== exp_data(exp_addr(req, i)) ||
              if4.rsp_last_41 !== (i == 7)) begin
            failures++;
            $display("FAIL beat%0d req=%h: addr=%h data=%h last=%b expected addr=%h data=%h last=%b",
                     i, req, if4.rsp_addr_41, if4.rsp_data_41, if4.rsp_last_41,
                     exp_addr(req, i), exp_data(exp_addr(req, i)), (i == 7));
          end
          i++;
        end
      end
    end
    if (i < stop_at) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout req=%h: got %0d beats expected %0d", req, i, stop_at);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_41);
    rst_41 = 1'b0;
    #1;
    checks++;
    if (if4.rsp_valid_41 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if4.rsp_valid_41); end
    checks++;
    if (if4.rsp_last_41 !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", if4.rsp_last_41); end
    checks++;
    if (if4.rsp_addr_41 !== 31'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", if4.rsp_addr_41); end
    checks++;
    if (if4.rsp_data_41 !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", if4.rsp_data_41); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++;
    if (ref4 !== 31'h0) begin failures++; $display("FAIL reset_refills: got %0d expected 0", ref4); end
    checks++;
    if (if4.req_ready_41 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", if4.req_ready_41); end
  endtask

  task automatic test_latency;
    send_req4(31'h48);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(posedge clk_41);
      else @(posedge clk_41);
      #1;
      checks++;
      if (if4.rsp_valid_41 !== (k == 5)) begin
        failures++;
        $display("FAIL latency_edge%0d: valid=%b expected %b", k, if4.rsp_valid_41, (k == 5));
      end
      if (k == 1) begin
        checks++;
        if (busy4 !== 1'b1) begin failures++; $display("FAIL busy_wait: got %b expected 1", busy4); end
      end
    end
    collect4(31'h48, 8, -1, 0);
    @(posedge clk_41); #1;
    checks++;
    if (ref4 !== 31'd1) begin failures++; $display("FAIL latency_refills: got %0d expected 1", ref4); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL latency_idle_busy: got %b expected 0", busy4); end
  endtask

  task automatic test_backpressure;
    send_req4(31'h48);
    collect4(31'h48, 8, 3, 3);
    @(posedge clk_41); #1;
    checks++;
    if (ref4 !== 31'd2) begin failures++; $display("FAIL bp_refills: got %0d expected 2", ref4); end
  endtask

  task automatic test_back_to_back;
    logic [30:0] a [4];
    a[0] = 31'h000; a[1] = 31'h100; a[2] = 31'h200; a[3] = 31'h300;
    if4.rsp_ready_41 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_41);
      if4.req_valid_41 = 1'b1;
      if4.req_addr_41  = a[k];
      checks++;
      if (if4.req_ready_41 !== (k < 3)) begin
        failures++;
        $display("FAIL b2b_ready%0d: got %b expected %b", k, if4.req_ready_41, (k < 3));
      end
    end
    repeat (10) @(negedge clk_41);
    checks++;
    if (if4.req_ready_41 !== 1'b0) begin failures++; $display("FAIL b2b_full_hold: got %b expected 0", if4.req_ready_41); end
    for (int k = 0; k < 4; k++) collect4(a[k], 8, -1, 0);
    @(posedge clk_41); #1;
    checks++;
    if (ref4 !== 31'd6) begin failures++; $display("FAIL b2b_refills: got %0d expected 6", ref4); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b expected 0", busy4); end
  endtask

  task automatic test_reset_mid_burst;
    send_req4(31'h000);
    collect4(31'h000, 5, -1, 0);
    @(posedge clk_41); #2;
    checks++;
    if (if4.rsp_valid_41 !== 1'b1 || if4.rsp_addr_41 !== exp_addr(31'h000, 5)) begin
      failures++;
      $display("FAIL mid_beat5: valid=%b addr=%h expected 1 %h", if4.rsp_valid_41, if4.rsp_addr_41, exp_addr(31'h000, 5));
    end
    rst_41 = 1'b1;
    #1;
    checks++;
    if (if4.rsp_valid_41 !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", if4.rsp_valid_41); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy4); end
    checks++;
    if (ref4 !== 31'd0) begin failures++; $display("FAIL rst_refills: got %0d expected 0", ref4); end
    checks++;
    if (if4.req_ready_41 !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b expected 1", if4.req_ready_41); end
    @(negedge clk_41);
    rst_41 = 1'b0;
    send_req4(31'h000);
    collect4(31'h000, 8, -1, 0);
    @(posedge clk_41); #1;
    checks++;
    if (ref4 !== 31'd1) begin failures++; $display("FAIL rst_recover_refills: got %0d expected 1", ref4); end
  endtask

  task automatic test_latency0;
    int i = 0;
    int guard = 0;
    @(negedge clk_41);
    if0.req_valid_41 = 1'b1;
    if0.req_addr_41  = 31'h20;
    @(posedge clk_41);
    #2 if0.req_valid_41 = 1'b0;
    checks++;
    if (if0.rsp_valid_41 !== 1'b0) begin failures++; $display("FAIL lat0_early: got %b expected 0", if0.rsp_valid_41); end
    @(posedge clk_41); #1;
    checks++;
    if (if0.rsp_valid_41 !== 1'b1) begin failures++; $display("FAIL lat0_first: got %b expected 1", if0.rsp_valid_41); end
    while (i < 8 && guard < 100) begin
      @(negedge clk_41);
      guard++;
      if (if0.rsp_valid_41) begin
        checks++;
        if (if0.rsp_addr_41 !== 31'h20 + 31'(4 * i) || if0.rsp_data_41 !== exp_data(31'h20 + 31'(4 * i)) ||
            if0.rsp_last_41 !== (i == 7)) begin
          failures++;
          $display("FAIL lat0_beat%0d: addr=%h data=%h last=%b expected addr=%h", i,
                   if0.rsp_addr_41, if0.rsp_data_41, if0.rsp_last_41, 31'h20 + 31'(4 * i));
        end
        i++;
      end
    end
    if (i < 8) begin
      checks++;
      failures++;
      $display("FAIL lat0_timeout: got %0d beats expected 8", i);
    end
    @(posedge clk_41); #1;
    checks++;
    if (ref0 !== 31'd1) begin failures++; $display("FAIL lat0_refills: got %0d expected 1", ref0); end
  endtask

  initial begin
    if4.req_valid_41 = 1'b0;
    if4.req_addr_41  = '0;
    if4.rsp_ready_41 = 1'b1;
    if0.req_valid_41 = 1'b0;
    if0.req_addr_41  = '0;
    if0.rsp_ready_41 = 1'b1;
    test_reset();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_latency0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
